alu_seq_muldiv: RTL and testbench

//  Parametrised, handshaked successor of the single-cycle execute ALU. Adds SLTU, MUL, MULH, DIV/DIVU, REM/REMU.

---
 rtl/alu_seq_muldiv.sv | 221 ++++++++++++++++++++++
 tb/tb_alu_seq_muldiv.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_muldiv.sv
// Execute-stage ALU with valid/ready handshakes. Logic and compare ops finish in one
// cycle; MUL/MULH/DIV/DIVU/REM/REMU run an iterative datapath, one bit per cycle.
module alu_seq_muldiv #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      aluctrl,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam int unsigned SHW = $clog2(XLEN);

    localparam logic [3:0] OpAnd  = 4'd0;
    localparam logic [3:0] OpOr   = 4'd1;
    localparam logic [3:0] OpAdd  = 4'd2;
    localparam logic [3:0] OpSub  = 4'd3;
    localparam logic [3:0] OpXor  = 4'd4;
    localparam logic [3:0] OpSlt  = 4'd5;
    localparam logic [3:0] OpSll  = 4'd6;
    localparam logic [3:0] OpSrl  = 4'd7;
    localparam logic [3:0] OpSra  = 4'd8;
    localparam logic [3:0] OpSltu = 4'd9;
    localparam logic [3:0] OpMul  = 4'd10;
    localparam logic [3:0] OpMulh = 4'd11;
    localparam logic [3:0] OpDiv  = 4'd12;
    localparam logic [3:0] OpDivu = 4'd13;
    localparam logic [3:0] OpRem  = 4'd14;
    localparam logic [3:0] OpRemu = 4'd15;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [XLEN-1:0] hi_q, hi_d;     // product high half / partial remainder
    logic [XLEN-1:0] lo_q, lo_d;     // multiplier bits / dividend-then-quotient
    logic [XLEN-1:0] opb_q, opb_d;   // multiplicand / divisor magnitude
    logic            neg_q, neg_d;   // negate the final magnitude
    logic [SHW:0]    cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;

    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] simple_res;
    logic            sgn_in, s1, s2;
    logic [XLEN-1:0] mag1, mag2;
    logic [XLEN:0]   mul_add, div_sh, div_diff;
    logic            div_ge;
    logic [XLEN-1:0] step_hi, step_lo, fin_res;

    // Single-cycle ops, computed straight from the presented operands
    always_comb begin
        shamt = src2[SHW-1:0];
        unique case (aluctrl)
            OpAnd:   simple_res = src1 & src2;
            OpOr:    simple_res = src1 | src2;
            OpAdd:   simple_res = src1 + src2;
            OpSub:   simple_res = src1 - src2;
            OpXor:   simple_res = src1 ^ src2;
            OpSlt:   simple_res = {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
            OpSll:   simple_res = src1 << shamt;
            OpSrl:   simple_res = src1 >> shamt;
            OpSra:   simple_res = $unsigned($signed(src1) >>> shamt);
            OpSltu:  simple_res = {{(XLEN-1){1'b0}}, src1 < src2};
            default: simple_res = '0;
        endcase
    end

    // Operand magnitudes for signed mul/div; MUL keeps raw operands (low half is sign-agnostic)
    always_comb begin
        sgn_in = (aluctrl == OpMulh) || (aluctrl == OpDiv) || (aluctrl == OpRem);
        s1     = sgn_in & src1[XLEN-1];
        s2     = sgn_in & src2[XLEN-1];
        mag1   = s1 ? (~src1 + 1'b1) : src1;
        mag2   = s2 ? (~src2 + 1'b1) : src2;
    end

    // One shift-add or restoring-divide iteration plus the final sign fix-up
    always_comb begin
        mul_add  = lo_q[0] ? ({1'b0, hi_q} + {1'b0, opb_q}) : {1'b0, hi_q};
        div_sh   = {hi_q, lo_q[XLEN-1]};
        div_diff = div_sh - {1'b0, opb_q};
        // Remainder stays below the divisor, so bit XLEN of the difference is the borrow
        div_ge   = ~div_diff[XLEN];
        if (op_q == OpMul || op_q == OpMulh) begin
            step_hi = mul_add[XLEN:1];
            step_lo = {mul_add[0], lo_q[XLEN-1:1]};
        end else begin
            step_hi = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], div_ge};
        end
        unique case (op_q)
            OpMul:   fin_res = step_lo;
            // High half of the negated 2*XLEN product: ~hi plus the carry out of -lo
            OpMulh:  fin_res = neg_q ? (~step_hi + {{(XLEN-1){1'b0}}, step_lo == '0}) : step_hi;
            OpDiv,
            OpDivu:  fin_res = neg_q ? (~step_lo + 1'b1) : step_lo;
            OpRem,
            OpRemu:  fin_res = neg_q ? (~step_hi + 1'b1) : step_hi;
            default: fin_res = step_lo;
        endcase
    end

    // Handshake FSM next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        opb_d       = opb_q;
        neg_d       = neg_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        if (flush) begin
            // Abort only; result/zero keep their last value
            state_d     = StIdle;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_d       = aluctrl;
                        in_ready_d = 1'b0;
                        if (aluctrl >= OpMul) begin
                            hi_d  = '0;
                            lo_d  = mag1;
                            opb_d = mag2;
                            unique case (aluctrl)
                                OpMulh:       neg_d = s1 ^ s2;
                                // x/0 must give all ones regardless of dividend sign
                                OpDiv:        neg_d = (s1 ^ s2) & (src2 != '0);
                                OpRem:        neg_d = s1;
                                default:      neg_d = 1'b0;
                            endcase
                            cnt_d   = (SHW+1)'(XLEN);
                            state_d = StBusy;
                        end else begin
                            result_d    = simple_res;
                            zero_d      = (simple_res == '0);
                            out_valid_d = 1'b1;
                            state_d     = StDone;
                        end
                    end
                end
                StBusy: begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == (SHW+1)'(1)) begin
                        result_d    = fin_res;
                        zero_d      = (fin_res == '0);
                        out_valid_d = 1'b1;
                        state_d     = StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        in_ready_d  = 1'b1;
                        state_d     = StIdle;
                    end
                end
                default: begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            op_q        <= OpAnd;
            hi_q        <= '0;
            lo_q        <= '0;
            opb_q       <= '0;
            neg_q       <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            opb_q       <= opb_d;
            neg_q       <= neg_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Directed bench for alu_seq_muldiv: hand-computed vectors, latency, handshake, flush, reset.
module tb_alu_seq_muldiv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  aluctrl;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int n_vec = 0;
    int n_err = 0;

    alu_seq_muldiv #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluctrl   (aluctrl),
        .src1      (src1),
        .src2      (src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one op from IDLE, wait (bounded) for the result, check it, then complete the handshake.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic exp_zero, input int exp_lat);
        int lat;
        int busy_rdy;
        in_valid = 1'b1;
        aluctrl  = op;
        src1     = a;
        src2     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        src1     = ~a;  // operands must have been sampled at the accept edge
        src2     = ~b;
        lat      = 1;
        busy_rdy = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_rdy++;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".rdy_busy"}, 32'(busy_rdy), 32'd0);
        chk({tag, ".res"}, result, exp_res);
        chk({tag, ".zero"}, {31'd0, zero}, {31'd0, exp_zero});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, ".idle"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        int bad;
        int seen;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        aluctrl   = 4'd0;
        src1      = '0;
        src2      = '0;
        #23;
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.result", result, 32'h0);
        chk("rst.zero", {31'd0, zero}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Simple ops
        run_op("add_wrap", 4'd2, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1);
        run_op("sub", 4'd3, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1);
        run_op("slt_neg", 4'd5, 32'hFFFF_FFFB, 32'd3, 32'h1, 1'b0, 1);
        run_op("slt_ovf", 4'd5, 32'h8000_0000, 32'h1, 32'h1, 1'b0, 1);
        run_op("sltu", 4'd9, 32'hFFFF_FFFB, 32'd3, 32'h0, 1'b1, 1);
        run_op("sll_amt", 4'd6, 32'h1, 32'h21, 32'h2, 1'b0, 1);
        run_op("sra", 4'd8, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1);
        run_op("srl", 4'd7, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1);

        // Multiply
        run_op("mul", 4'd10, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, 33);
        run_op("mulh_neg", 4'd11, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);
        run_op("mulh_min", 4'd11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 33);

        // Divide / remainder
        run_op("div", 4'd12, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33);
        run_op("rem", 4'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);
        run_op("divu_0", 4'd13, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 33);
        run_op("remu_0", 4'd15, 32'd9, 32'd0, 32'd9, 1'b0, 33);
        run_op("div_neg_0", 4'd12, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1'b0, 33);
        run_op("rem_neg_0", 4'd14, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b0, 33);
        run_op("div_ovf", 4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33);
        run_op("rem_ovf", 4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1, 33);
        run_op("divu", 4'd13, 32'd100, 32'd7, 32'd14, 1'b0, 33);

        // Back-pressure: result held, new op ignored while DONE
        in_valid = 1'b1;
        aluctrl  = 4'd4;
        src1     = 32'hF0F0_F0F0;
        src2     = 32'hFF00_FF00;
        @(posedge clk);
        #1;
        aluctrl = 4'd2;
        src1    = 32'd1;
        src2    = 32'd1;
        bad     = 0;
        for (int i = 0; i < 10; i++) begin
            if (!out_valid || in_ready || result !== 32'h0FF0_0FF0 || zero !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        chk("hold.stable", 32'(bad), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("hold.release", {30'd0, out_valid, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("hold.no_accept", {31'd0, out_valid}, 32'd0);

        // Flush in BUSY cycle 5, with a competing in_valid
        in_valid = 1'b1;
        aluctrl  = 4'd13;
        src1     = 32'd100;
        src2     = 32'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        flush    = 1'b1;
        in_valid = 1'b1;
        aluctrl  = 4'd2;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush.idle", {30'd0, out_valid, in_ready}, 32'd1);
        chk("flush.keep_res", result, 32'h0FF0_0FF0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            @(posedge clk);
            #1;
        end
        chk("flush.no_out", 32'(seen), 32'd0);

        // Async reset in BUSY cycle 12 of a MUL
        in_valid = 1'b1;
        aluctrl  = 4'd10;
        src1     = 32'd3;
        src2     = 32'd5;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #4;
        rst_n = 1'b0;
        #1;
        chk("rst_busy.idle", {30'd0, out_valid, in_ready}, 32'd1);
        chk("rst_busy.result", result, 32'h0);
        #2;
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("rst_busy.no_out", 32'(seen), 32'd0);

        run_op("add_after", 4'd2, 32'd3, 32'd4, 32'd7, 1'b0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired: observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
